bram_stream_uart: RTL and testbench

- Parametrised successor to the single-byte BRAM-to-UART dumper.
- After a start event, reads NUM_WORDS words of DATA_W bits from a synchronous BRAM port, starting at BASE_ADDR.
- Serialises each word LSB-byte-first into an external uart_tx core through a tx_start/tx_busy handshake.
- Re-armable for repeated dumps of the ANC filter output buffer without a global reset.

---
 rtl/bram_stream_uart_if.sv | 15 +
 rtl/bram_stream_uart.sv | 174 +++++++++++++++++
 tb/tb_bram_stream_uart.sv | 244 ++++++++++++++++++++++++
 3 files changed

// File: rtl/bram_stream_uart_if.sv
// Bus bundle for bram_stream_uart: synchronous BRAM read port plus the uart_tx start/busy handshake.
interface bram_stream_uart_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 10
);
    logic              ena;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] dout;
    logic              tx_start;
    logic [7:0]        tx_data;
    logic              tx_busy;

    modport master (output ena, addr, tx_start, tx_data, input dout, tx_busy);
    modport slave  (input ena, addr, tx_start, tx_data, output dout, tx_busy);
endinterface

// File: rtl/bram_stream_uart.sv
// Re-armable BRAM-to-UART dumper: streams NUM_WORDS words from BASE_ADDR, LSB byte first.
// Define BRAM_STREAM_CHECKSUM_EN to append a modulo-256 sum byte after the payload.
module bram_stream_uart #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 10,
    parameter int NUM_WORDS = 124,
    parameter int BASE_ADDR = 0,
    parameter int RD_LAT    = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    bram_stream_uart_if.master bus,
    output logic               busy,
    output logic               done
);
    // state    | meaning
    // IDLE     | out of reset, waiting for a start request
    // RD_ISSUE | present ena/addr for the current word
    // RD_WAIT  | wait out BRAM latency, then capture the word
    // TX_REQ   | hand the next byte to uart_tx once it is idle
    // TX_WAIT  | wait for uart_tx to finish the byte
    // NEXT     | advance to the next word or finish
    // DONE     | dump complete, done held high, re-armable
    // CKSUM    | send the sum byte (checksum build only)
    localparam int BYTES = DATA_W / 8;
    localparam int WC_W  = (NUM_WORDS > 1) ? $clog2(NUM_WORDS) : 1;
    localparam int BC_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int LC_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] RD_ISSUE = 3'd1;
    localparam logic [2:0] RD_WAIT  = 3'd2;
    localparam logic [2:0] TX_REQ   = 3'd3;
    localparam logic [2:0] TX_WAIT  = 3'd4;
    localparam logic [2:0] NEXT     = 3'd5;
    localparam logic [2:0] DONE     = 3'd6;
`ifdef BRAM_STREAM_CHECKSUM_EN
    localparam logic [2:0] CKSUM    = 3'd7;
`endif

    logic [2:0]        state;
    logic              start_pend;
    logic [WC_W-1:0]   word_ctr;
    logic [BC_W-1:0]   byte_ctr;
    logic [LC_W-1:0]   lat_ctr;
    logic [DATA_W-1:0] shift;
    logic              tx_first;
    logic              ena_q;
    logic [ADDR_W-1:0] addr_q;
    logic              tx_start_q;
    logic [7:0]        tx_data_q;
`ifdef BRAM_STREAM_CHECKSUM_EN
    logic [7:0]        sum;
    logic              cks_sent;
`endif

    assign bus.ena      = ena_q;
    assign bus.addr     = addr_q;
    assign bus.tx_start = tx_start_q;
    assign bus.tx_data  = tx_data_q;

    assign done = (state == DONE);
    assign busy = (state != IDLE) && (state != DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            start_pend <= 1'b0;
            word_ctr   <= '0;
            byte_ctr   <= '0;
            lat_ctr    <= '0;
            shift      <= '0;
            tx_first   <= 1'b0;
            ena_q      <= 1'b0;
            addr_q     <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
`ifdef BRAM_STREAM_CHECKSUM_EN
            sum        <= '0;
            cks_sent   <= 1'b0;
`endif
        end else begin
            tx_start_q <= 1'b0;
            case (state)
                IDLE, DONE: begin
                    // start is only latched while no dump is running
                    if (start_pend) begin
                        start_pend <= 1'b0;
                        word_ctr   <= '0;
                        state      <= RD_ISSUE;
`ifdef BRAM_STREAM_CHECKSUM_EN
                        sum        <= '0;
                        cks_sent   <= 1'b0;
`endif
                    end else if (start) begin
                        start_pend <= 1'b1;
                    end
                end
                RD_ISSUE: begin
                    ena_q   <= 1'b1;
                    addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(word_ctr);
                    lat_ctr <= '0;
                    state   <= RD_WAIT;
                end
                RD_WAIT: begin
                    lat_ctr <= lat_ctr + LC_W'(1);
                    if (lat_ctr == LC_W'(RD_LAT - 1)) begin
                        shift    <= bus.dout;
                        ena_q    <= 1'b0;
                        byte_ctr <= '0;
                        state    <= TX_REQ;
                    end
                end
                TX_REQ: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= shift[7:0];
                        tx_first   <= 1'b1;
                        state      <= TX_WAIT;
`ifdef BRAM_STREAM_CHECKSUM_EN
                        sum        <= sum + shift[7:0];
`endif
                    end
                end
                TX_WAIT: begin
                    // uart_tx raises busy one cycle after the pulse, so skip that cycle
                    tx_first <= 1'b0;
                    if (!tx_first && !bus.tx_busy) begin
`ifdef BRAM_STREAM_CHECKSUM_EN
                        if (cks_sent) begin
                            state <= DONE;
                        end else begin
`else
                        begin
`endif
                            shift <= shift >> 8;
                            if (byte_ctr == BC_W'(BYTES - 1)) begin
                                state <= NEXT;
                            end else begin
                                byte_ctr <= byte_ctr + BC_W'(1);
                                state    <= TX_REQ;
                            end
                        end
                    end
                end
                NEXT: begin
                    if (word_ctr == WC_W'(NUM_WORDS - 1)) begin
`ifdef BRAM_STREAM_CHECKSUM_EN
                        state <= CKSUM;
`else
                        state <= DONE;
`endif
                    end else begin
                        word_ctr <= word_ctr + WC_W'(1);
                        state    <= RD_ISSUE;
                    end
                end
`ifdef BRAM_STREAM_CHECKSUM_EN
                CKSUM: begin
                    if (!bus.tx_busy) begin
                        tx_start_q <= 1'b1;
                        tx_data_q  <= sum;
                        tx_first   <= 1'b1;
                        cks_sent   <= 1'b1;
                        state      <= TX_WAIT;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_bram_stream_uart.sv
// Scoreboard bench for bram_stream_uart: five parameterisations sharing clk/reset, each with a BRAM and uart_tx model.
module tb_bram_stream_uart;
    localparam int NI = 5;

    logic          clk;
    logic          reset;
    logic [NI-1:0] start;
    logic [NI-1:0] busy;
    logic [NI-1:0] done;
    logic [NI-1:0] txs;
    logic [NI-1:0] en;
    logic [7:0]    txd [NI];
    logic [9:0]    ad  [NI];

    logic [31:0]   mem [NI][1024];

    logic [7:0]    eb  [NI][4];
    int            nb  [NI];
    logic [7:0]    cks [NI];
    logic [9:0]    ea  [NI][4];
    int            nw  [NI];

    logic [7:0]    byte_q [NI][$];
    logic [9:0]    addr_q [NI][$];
    int            byte_cnt [NI];
    int            en_len   [NI];
    logic          en_prev  [NI];

    int n_chk;
    int n_pass;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int DW = (g == 1) ? 16 : (g == 4) ? 32 : 8;
        localparam int NW = (g == 0 || g == 2) ? 4 : (g == 1) ? 2 : (g == 3) ? 3 : 1;
        localparam int BA = (g == 0) ? 16 : (g == 1) ? 0 : (g == 2) ? 1022 : (g == 3) ? 32 : 5;

        bram_stream_uart_if #(.DATA_W(DW), .ADDR_W(10)) bus ();
        logic [3:0] ucnt;

        bram_stream_uart #(
            .DATA_W(DW), .ADDR_W(10), .NUM_WORDS(NW), .BASE_ADDR(BA), .RD_LAT(2)
        ) u_dut (
            .clk(clk), .reset(reset), .start(start[g]), .bus(bus),
            .busy(busy[g]), .done(done[g])
        );

        // registered-output BRAM; junk on dout whenever the port is disabled
        always_ff @(posedge clk) begin
            if (bus.ena) bus.dout <= DW'(mem[g][bus.addr]);
            else         bus.dout <= DW'(32'h5A5A5A5A);
        end

        // uart_tx: busy for 10 cycles starting the cycle after tx_start
        always_ff @(posedge clk) begin
            if (reset)             ucnt <= 4'd0;
            else if (bus.tx_start) ucnt <= 4'd10;
            else if (ucnt != 4'd0) ucnt <= ucnt - 4'd1;
        end
        assign bus.tx_busy = (ucnt != 4'd0);

        assign txs[g] = bus.tx_start;
        assign txd[g] = bus.tx_data;
        assign en[g]  = bus.ena;
        assign ad[g]  = bus.addr;
    end

    function automatic void chk(string name, int i, longint act, longint exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s inst%0d: got 0x%0h expected 0x%0h", name, i, act, exp);
    endfunction

    task automatic monitor();
        forever begin
            @(negedge clk);
            for (int i = 0; i < NI; i++) begin
                if (reset) begin
                    en_prev[i] = 1'b0;
                    en_len[i]  = 0;
                end else begin
                    if (txs[i]) begin
                        byte_cnt[i]++;
                        if (byte_q[i].size() == 0) chk("unexpected_byte", i, txd[i], -1);
                        else chk("tx_data", i, txd[i], byte_q[i].pop_front());
                    end
                    if (en[i] && !en_prev[i]) begin
                        if (addr_q[i].size() == 0) chk("unexpected_read", i, ad[i], -1);
                        else chk("addr", i, ad[i], addr_q[i].pop_front());
                    end
                    if (en[i]) en_len[i]++;
                    if (!en[i] && en_prev[i]) begin
                        chk("ena_len", i, en_len[i], 2);
                        en_len[i] = 0;
                    end
                    en_prev[i] = en[i];
                end
            end
        end
    endtask

    function automatic int exp_bytes(int i);
`ifdef BRAM_STREAM_CHECKSUM_EN
        return nb[i] + 1;
`else
        return nb[i];
`endif
    endfunction

    task automatic queue_dump(int i);
        for (int b = 0; b < nb[i]; b++) byte_q[i].push_back(eb[i][b]);
`ifdef BRAM_STREAM_CHECKSUM_EN
        byte_q[i].push_back(cks[i]);
`endif
        for (int w = 0; w < nw[i]; w++) addr_q[i].push_back(ea[i][w]);
    endtask

    task automatic pulse_start(int i);
        @(posedge clk); #1 start[i] = 1'b1;
        @(posedge clk); #1 start[i] = 1'b0;
    endtask

    task automatic wait_done(int i, int budget);
        int k;
        k = 0;
        while (!done[i] && k < budget) begin
            @(negedge clk);
            k++;
        end
        chk("done_timeout", i, done[i], 1);
    endtask

    task automatic run_dump(int i);
        int c0;
        c0 = byte_cnt[i];
        queue_dump(i);
        pulse_start(i);
        @(negedge clk); @(negedge clk);
        chk("done_cleared", i, done[i], 0);
        chk("busy_running", i, busy[i], 1);
        wait_done(i, 400);
        chk("busy_after", i, busy[i], 0);
        chk("byte_count", i, byte_cnt[i] - c0, exp_bytes(i));
        chk("bytes_left", i, byte_q[i].size(), 0);
        chk("reads_left", i, addr_q[i].size(), 0);
    endtask

    initial begin
        int c0;
        int k;
        n_chk  = 0;
        n_pass = 0;
        reset  = 1'b1;
        start  = '0;
        for (int i = 0; i < NI; i++) begin
            byte_cnt[i] = 0;
            en_len[i]   = 0;
            en_prev[i]  = 1'b0;
        end

        mem[0][16] = 32'h11; mem[0][17] = 32'h22; mem[0][18] = 32'h33; mem[0][19] = 32'h44;
        eb[0] = '{8'h11, 8'h22, 8'h33, 8'h44}; nb[0] = 4; cks[0] = 8'hAA;
        ea[0] = '{10'd16, 10'd17, 10'd18, 10'd19}; nw[0] = 4;

        mem[1][0] = 32'hBEEF; mem[1][1] = 32'h8001;
        eb[1] = '{8'hEF, 8'hBE, 8'h01, 8'h80}; nb[1] = 4; cks[1] = 8'h2E;
        ea[1] = '{10'd0, 10'd1, 10'd0, 10'd0}; nw[1] = 2;

        mem[2][1022] = 32'hA1; mem[2][1023] = 32'hA2; mem[2][0] = 32'hA3; mem[2][1] = 32'hA4;
        eb[2] = '{8'hA1, 8'hA2, 8'hA3, 8'hA4}; nb[2] = 4; cks[2] = 8'h8A;
        ea[2] = '{10'd1022, 10'd1023, 10'd0, 10'd1}; nw[2] = 4;

        mem[3][32] = 32'hFF; mem[3][33] = 32'h02; mem[3][34] = 32'h10;
        eb[3] = '{8'hFF, 8'h02, 8'h10, 8'h00}; nb[3] = 3; cks[3] = 8'h11;
        ea[3] = '{10'd32, 10'd33, 10'd34, 10'd0}; nw[3] = 3;

        mem[4][5] = 32'hCAFEF00D;
        eb[4] = '{8'h0D, 8'hF0, 8'hFE, 8'hCA}; nb[4] = 4; cks[4] = 8'hC5;
        ea[4] = '{10'd5, 10'd0, 10'd0, 10'd0}; nw[4] = 1;

        fork
            monitor();
        join_none

        repeat (4) @(negedge clk);
        chk("rst_ena", 0, en[0], 0);
        chk("rst_addr", 0, ad[0], 0);
        chk("rst_tx_start", 0, txs[0], 0);
        chk("rst_tx_data", 0, txd[0], 0);
        for (int i = 0; i < NI; i++) begin
            chk("rst_busy", i, busy[i], 0);
            chk("rst_done", i, done[i], 0);
        end
        @(posedge clk); #1 reset = 1'b0;

        for (int i = 0; i < NI; i++) run_dump(i);

        // start pulse while busy must be dropped; start while done re-arms
        c0 = byte_cnt[0];
        queue_dump(0);
        pulse_start(0);
        @(negedge clk); @(negedge clk);
        chk("rearm_done_drop", 0, done[0], 0);
        repeat (20) @(negedge clk);
        chk("busy_mid", 0, busy[0], 1);
        pulse_start(0);
        wait_done(0, 400);
        repeat (40) @(negedge clk);
        chk("ignored_start_count", 0, byte_cnt[0] - c0, exp_bytes(0));
        chk("ignored_start_done", 0, done[0], 1);

        // reset during the second word's read
        queue_dump(0);
        pulse_start(0);
        k = 0;
        while (!(en[0] && ad[0] == 10'd17) && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("second_word_seen", 0, en[0], 1);
        @(posedge clk); #1 reset = 1'b1;
        #1;
        chk("async_ena", 0, en[0], 0);
        chk("async_tx_start", 0, txs[0], 0);
        chk("async_busy", 0, busy[0], 0);
        chk("async_done", 0, done[0], 0);
        chk("bytes_pending_at_reset", 0, byte_q[0].size(), exp_bytes(0) - 1);
        byte_q[0].delete();
        addr_q[0].delete();
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        run_dump(0);

        for (int i = 0; i < NI; i++) begin
            chk("final_bytes_left", i, byte_q[i].size(), 0);
            chk("final_reads_left", i, addr_q[i].size(), 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
